// File: rtl/fbwr_pkg.sv
// Shared definitions for the frame-buffer DDRAM write buffer: entry layout, byte-enable patterns, default region base.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fbwr_pkg;

  // Queued entry: {fb[1:0], addr[22:2], data[31:0]}
  localparam int ENTRY_W = 55;

  // DDRAM region base; the frame buffers start at 0x24000000, 8 MB each
  localparam logic [6:0] MEM_BASE_DEF = 7'b0010010;

  // Byte enables for the low pixel, the high pixel and a fully merged word
  localparam logic [7:0] BE_LO  = 8'h0F;
  localparam logic [7:0] BE_HI  = 8'hF0;
  localparam logic [7:0] BE_ALL = 8'hFF;

  typedef struct packed {
    logic [1:0]  fb;
    logic [20:0] addr;   // byte address bits [22:2]
    logic [31:0] data;
  } fbwr_entry_t;

  // addr[2] selects which 32-bit half of the 64-bit word a pixel lands in
  function automatic logic [7:0] half_be(input logic hi);
    return hi ? BE_HI : BE_LO;
  endfunction

endpackage

// File: rtl/fbwr_fifo.sv
// Simple-dual-port RAM FIFO with registered level, full and empty flags.
// Latency: a push is visible at the head (empty=0) one cycle later; the head is read combinationally from RAM.
// Backpressure: pushes while full are ignored (the caller flags them); pops while empty are ignored.
import fbwr_pkg::*;

module fbwr_fifo #(
  parameter int W     = ENTRY_W,
  parameter int DEPTH = 16,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [W-1:0]  din_i,
  input  logic          pop_i,
  output logic [W-1:0]  dout_o,
  output logic [LW-1:0] level_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q, level_d;
  logic          full_q, empty_q;
  logic          push_ok, pop_ok;

  // Flags come from registered state only, so a pop cannot make room for a same-cycle push
  assign push_ok = push_i && !full_q;
  assign pop_ok  = pop_i && !empty_q;
  assign level_d = level_q + LW'(push_ok) - LW'(pop_ok);

  // Storage array; no reset needed since contents are only read behind a valid level
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din_i;
  end

  // Pointers wrap naturally since DEPTH is a power of two; flags are precomputed from next level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_d;
      full_q  <= (level_d == LW'(DEPTH));
      empty_q <= (level_d == '0);
    end
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/fb_ddram_wrbuf.sv
// Queues 32-bit frame-buffer pixel writes and issues them to DDRAM as single-beat 64-bit writes (optional pixel-pair merge: JTFRAME_FBWR_MERGE_EN).
// Latency: wr_req at cycle N shows DDRAM_WE at N+2 when idle; one write per clock sustained.
// Backpressure: DDRAM_BUSY holds the pending write; FIFO absorbs DEPTH more, further requests drop and set overflow.
import fbwr_pkg::*;

module fb_ddram_wrbuf #(
  parameter logic [6:0] MEM_BASE = MEM_BASE_DEF,
  parameter int         DEPTH    = 16,
  parameter int         LW       = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_req,
  input  logic [1:0]    wr_fb,
  input  logic [22:0]   wr_addr,
  input  logic [31:0]   wr_data,
  output logic          full,
  output logic          overflow,
  input  logic          ovf_clr,
  output logic [LW-1:0] level,
  input  logic          DDRAM_BUSY,
  output logic [7:0]    DDRAM_BURSTCNT,
  output logic [28:0]   DDRAM_ADDR,
  output logic [63:0]   DDRAM_DIN,
  output logic [7:0]    DDRAM_BE,
  output logic          DDRAM_WE,
  output logic          DDRAM_RD
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_PEND = 1'b1;

  fbwr_entry_t          push_ent, head;
  logic [ENTRY_W-1:0]   head_raw;
  logic                 fifo_empty;
  logic                 pop, load, merge_ok;
  logic                 ovf_q, ovf_d;
  logic [0:0]           state_q, state_d;
  logic [28:0]          addr_q, addr_d;
  logic [63:0]          din_q, din_d;
  logic [7:0]           be_q, be_d;
  logic                 unused_addr_lsb;

  // Byte-lane bits of the address carry no information for 32-bit pixels
  assign unused_addr_lsb = ^wr_addr[1:0];

  assign push_ent = '{fb: wr_fb, addr: wr_addr[22:2], data: wr_data};
  assign head     = fbwr_entry_t'(head_raw);

  fbwr_fifo #(
    .W     (ENTRY_W),
    .DEPTH (DEPTH),
    .LW    (LW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (wr_req),
    .din_i   (push_ent),
    .pop_i   (pop),
    .dout_o  (head_raw),
    .level_o (level),
    .full_o  (full),
    .empty_o (fifo_empty)
  );

  // Sticky drop flag; a drop in the same cycle as a clear wins
  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clr)         ovf_d = 1'b0;
    if (wr_req && full)  ovf_d = 1'b1;
  end

`ifdef JTFRAME_FBWR_MERGE_EN
  // Fold the head into a stalled word when it targets the other, still-empty half of the same 64-bit word.
  // Requiring the target half's enables to be zero also rules out a second merge once BE is 8'hFF.
  assign merge_ok = (state_q == ST_PEND) && DDRAM_BUSY && !fifo_empty
                 && (head.fb == addr_q[21:20])
                 && (head.addr[20:1] == addr_q[19:0])
                 && (head.addr[0] ? (be_q[7:4] == 4'h0) : (be_q[3:0] == 4'h0));
`else
  assign merge_ok = 1'b0;
`endif

  // Output register control: load the head when idle or when the pending write is accepted
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    din_d   = din_q;
    be_d    = be_q;
    pop     = 1'b0;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) load = 1'b1;
      end
      ST_PEND: begin
        if (!DDRAM_BUSY) begin
          if (!fifo_empty) load = 1'b1;
          else             state_d = ST_IDLE;
        end else if (merge_ok) begin
          pop = 1'b1;
          if (head.addr[0]) din_d[63:32] = head.data;
          else              din_d[31:0]  = head.data;
          be_d = BE_ALL;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (load) begin
      pop     = 1'b1;
      state_d = ST_PEND;
      addr_d  = {MEM_BASE, head.fb, head.addr[20:1]};
      din_d   = {head.data, head.data};
      be_d    = half_be(head.addr[0]);
    end
  end

  // State and output register; reset abandons any pending write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      din_q   <= '0;
      be_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      be_q    <= be_d;
      ovf_q   <= ovf_d;
    end
  end

  assign overflow       = ovf_q;
  assign DDRAM_WE       = (state_q == ST_PEND);
  assign DDRAM_ADDR     = addr_q;
  assign DDRAM_DIN      = din_q;
  assign DDRAM_BE       = be_q;
  assign DDRAM_BURSTCNT = 8'd1;
  assign DDRAM_RD       = 1'b0;

endmodule

// File: tb/tb_fb_ddram_wrbuf.sv
// Self-checking bench for fb_ddram_wrbuf: directed vector table plus multi-cycle corner sequences.
// Latency: n/a.
// Backpressure: DDRAM_BUSY driven directly by the bench.
module tb_fb_ddram_wrbuf;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_req;
  logic [1:0]  wr_fb;
  logic [22:0] wr_addr;
  logic [31:0] wr_data;
  logic        full;
  logic        overflow;
  logic        ovf_clr;
  logic [4:0]  level;
  logic        DDRAM_BUSY;
  logic [7:0]  DDRAM_BURSTCNT;
  logic [28:0] DDRAM_ADDR;
  logic [63:0] DDRAM_DIN;
  logic [7:0]  DDRAM_BE;
  logic        DDRAM_WE;
  logic        DDRAM_RD;

  fb_ddram_wrbuf dut (
    .clk            (clk),
    .rst            (rst),
    .wr_req         (wr_req),
    .wr_fb          (wr_fb),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .full           (full),
    .overflow       (overflow),
    .ovf_clr        (ovf_clr),
    .level          (level),
    .DDRAM_BUSY     (DDRAM_BUSY),
    .DDRAM_BURSTCNT (DDRAM_BURSTCNT),
    .DDRAM_ADDR     (DDRAM_ADDR),
    .DDRAM_DIN      (DDRAM_DIN),
    .DDRAM_BE       (DDRAM_BE),
    .DDRAM_WE       (DDRAM_WE),
    .DDRAM_RD       (DDRAM_RD)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  fb;
    logic [22:0] addr;
    logic [31:0] data;
    logic [28:0] exp_addr;
    logic [63:0] exp_din;
    logic [7:0]  exp_be;
  } vec_t;

  typedef struct {
    logic [28:0] a;
    logic [63:0] d;
    logic [7:0]  b;
    int          cyc;
  } acc_t;

  acc_t acc_q[$];
  int   cyc_cnt = 0;
  int   pass_cnt = 0;
  int   tot_cnt = 0;
  vec_t vt[4];

  // Record every accepted DDRAM write with its cycle stamp
  always @(posedge clk) begin
    cyc_cnt++;
    if (!rst && DDRAM_WE && !DDRAM_BUSY)
      acc_q.push_back('{DDRAM_ADDR, DDRAM_DIN, DDRAM_BE, cyc_cnt});
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tot_cnt++;
    if (act !== exp) $display("FAIL %s actual=%h required=%h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [1:0] f, input logic [22:0] a, input logic [31:0] d);
    wr_req  = 1'b1;
    wr_fb   = f;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_req  = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((DDRAM_WE || level != 5'd0) && n < 100) begin
      tick();
      n++;
    end
    chk("drain_done", 64'(n < 100), 64'(1));
  endtask

  // One isolated write with BUSY low: WE at N+2 for exactly one cycle
  task automatic single_vec(input vec_t v);
    acc_q.delete();
    req(v.fb, v.addr, v.data);
    chk("sv_level_n1", 64'(level), 64'(1));
    chk("sv_we_n1", 64'(DDRAM_WE), 64'(0));
    tick();
    chk("sv_we_n2", 64'(DDRAM_WE), 64'(1));
    chk("sv_addr", 64'(DDRAM_ADDR), 64'(v.exp_addr));
    chk("sv_din", DDRAM_DIN, v.exp_din);
    chk("sv_be", 64'(DDRAM_BE), 64'(v.exp_be));
    chk("sv_level_n2", 64'(level), 64'(0));
    tick();
    chk("sv_we_n3", 64'(DDRAM_WE), 64'(0));
    chk("sv_acc_count", 64'(acc_q.size()), 64'(1));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vt[0] = '{2'd1, 23'h000104, 32'h00112233, {7'b0010010, 2'd1, 20'h00020}, 64'h00112233_00112233, 8'hF0};
    vt[1] = '{2'd0, 23'h000000, 32'h00ABCDEF, {7'b0010010, 2'd0, 20'h00000}, 64'h00ABCDEF_00ABCDEF, 8'h0F};
    vt[2] = '{2'd3, 23'h7FFFFF, 32'h00FFFFFF, {7'b0010010, 2'd3, 20'hFFFFF}, 64'h00FFFFFF_00FFFFFF, 8'hF0};
    vt[3] = '{2'd2, 23'h123459, 32'h00010203, {7'b0010010, 2'd2, 20'h2468B}, 64'h00010203_00010203, 8'h0F};

    rst = 1'b1; wr_req = 1'b0; wr_fb = '0; wr_addr = '0; wr_data = '0;
    ovf_clr = 1'b0; DDRAM_BUSY = 1'b0;
    tick(); tick();
    chk("rst_we", 64'(DDRAM_WE), 64'(0));
    chk("rst_level", 64'(level), 64'(0));
    chk("rst_full", 64'(full), 64'(0));
    chk("rst_ovf", 64'(overflow), 64'(0));
    chk("rst_addr", 64'(DDRAM_ADDR), 64'(0));
    chk("rst_din", DDRAM_DIN, 64'(0));
    chk("rst_be", 64'(DDRAM_BE), 64'(0));
    chk("burstcnt", 64'(DDRAM_BURSTCNT), 64'(1));
    chk("rd", 64'(DDRAM_RD), 64'(0));
    rst = 1'b0;
    tick();

    for (int i = 0; i < 4; i++) single_vec(vt[i]);

    // BUSY held for 5 cycles on a pending write
    acc_q.delete();
    DDRAM_BUSY = 1'b1;
    req(2'd1, 23'h000104, 32'h00112233);
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("hold_we", 64'(DDRAM_WE), 64'(1));
      chk("hold_addr", 64'(DDRAM_ADDR), 64'({7'b0010010, 2'd1, 20'h00020}));
      chk("hold_din", DDRAM_DIN, 64'h00112233_00112233);
      chk("hold_be", 64'(DDRAM_BE), 64'(8'hF0));
      tick();
    end
    DDRAM_BUSY = 1'b0;
    tick();
    chk("hold_we_after", 64'(DDRAM_WE), 64'(0));
    chk("hold_acc_count", 64'(acc_q.size()), 64'(1));

    // Adjacent-pixel pair while stalled
    acc_q.delete();
    DDRAM_BUSY = 1'b1;
    req(2'd1, 23'h000104, 32'h00112233);
    req(2'd1, 23'h000100, 32'h00445566);
    chk("pair_we", 64'(DDRAM_WE), 64'(1));
    tick();
`ifdef JTFRAME_FBWR_MERGE_EN
    chk("merge_level", 64'(level), 64'(0));
    chk("merge_be", 64'(DDRAM_BE), 64'(8'hFF));
    chk("merge_din", DDRAM_DIN, 64'h00112233_00445566);
`else
    chk("nomerge_level", 64'(level), 64'(1));
    chk("nomerge_be", 64'(DDRAM_BE), 64'(8'hF0));
    chk("nomerge_din", DDRAM_DIN, 64'h00112233_00112233);
`endif
    tick(); tick();
    DDRAM_BUSY = 1'b0;
    drain();
`ifdef JTFRAME_FBWR_MERGE_EN
    chk("merge_acc_count", 64'(acc_q.size()), 64'(1));
    if (acc_q.size() >= 1) begin
      chk("merge_acc_din", acc_q[0].d, 64'h00112233_00445566);
      chk("merge_acc_be", 64'(acc_q[0].b), 64'(8'hFF));
    end
`else
    chk("pair_acc_count", 64'(acc_q.size()), 64'(2));
    if (acc_q.size() >= 2) begin
      chk("pair_acc0_din", acc_q[0].d, 64'h00112233_00112233);
      chk("pair_acc0_be", 64'(acc_q[0].b), 64'(8'hF0));
      chk("pair_acc1_din", acc_q[1].d, 64'h00445566_00445566);
      chk("pair_acc1_be", 64'(acc_q[1].b), 64'(8'h0F));
      chk("pair_acc1_addr", 64'(acc_q[1].a), 64'({7'b0010010, 2'd1, 20'h00020}));
    end
`endif

    // Burst of 20 with BUSY high: 17 fit (FIFO + output register), 3 drop
    acc_q.delete();
    DDRAM_BUSY = 1'b1;
    for (int i = 0; i < 20; i++) begin
      int exp_lvl;
      wr_req = 1'b1; wr_fb = 2'd0; wr_addr = 23'(i * 8); wr_data = 32'(256 + i);
      tick();
      exp_lvl = (i == 0) ? 1 : ((i > 16) ? 16 : i);
      chk("burst_level", 64'(level), 64'(exp_lvl));
      chk("burst_full", 64'(full), 64'(exp_lvl == 16));
      chk("burst_ovf", 64'(overflow), 64'(i >= 17));
    end
    wr_req = 1'b0;
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_cleared", 64'(overflow), 64'(0));
    ovf_clr = 1'b1; wr_req = 1'b1; wr_addr = 23'h000400; wr_data = 32'h00DEAD00;
    tick();
    ovf_clr = 1'b0; wr_req = 1'b0;
    chk("ovf_clr_and_drop", 64'(overflow), 64'(1));
    chk("drop_level", 64'(level), 64'(16));
    tick();
    chk("ovf_sticky", 64'(overflow), 64'(1));
    DDRAM_BUSY = 1'b0;
    drain();
    chk("burst_acc_count", 64'(acc_q.size()), 64'(17));
    for (int k = 0; k < 17 && k < acc_q.size(); k++) begin
      chk("burst_acc_din", acc_q[k].d, {32'(256 + k), 32'(256 + k)});
      chk("burst_acc_addr", 64'(acc_q[k].a), 64'({7'b0010010, 2'd0, 20'(k)}));
    end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_final_clear", 64'(overflow), 64'(0));

    // Back-to-back writes with BUSY low
    acc_q.delete();
    for (int i = 0; i < 8; i++) begin
      wr_req = 1'b1; wr_fb = 2'd2; wr_addr = 23'(i * 8 + 4); wr_data = 32'(512 + i);
      tick();
      chk("b2b_level", 64'(level), 64'(1));
    end
    wr_req = 1'b0;
    drain();
    chk("b2b_acc_count", 64'(acc_q.size()), 64'(8));
    for (int k = 0; k < 8 && k < acc_q.size(); k++) begin
      chk("b2b_acc_din", acc_q[k].d, {32'(512 + k), 32'(512 + k)});
      chk("b2b_acc_be", 64'(acc_q[k].b), 64'(8'hF0));
      chk("b2b_acc_cycle", 64'(acc_q[k].cyc - acc_q[0].cyc), 64'(k));
    end

    // Simultaneous push and pop at level 8
    acc_q.delete();
    DDRAM_BUSY = 1'b1;
    for (int i = 0; i < 9; i++) begin
      wr_req = 1'b1; wr_fb = 2'd0; wr_addr = 23'(i * 8); wr_data = 32'(768 + i);
      tick();
    end
    chk("pp_level_before", 64'(level), 64'(8));
    DDRAM_BUSY = 1'b0;
    wr_addr = 23'(9 * 8); wr_data = 32'(768 + 9);
    tick();
    wr_req = 1'b0;
    chk("pp_level_after", 64'(level), 64'(8));
    drain();
    chk("pp_acc_count", 64'(acc_q.size()), 64'(10));
    for (int k = 0; k < 10 && k < acc_q.size(); k++)
      chk("pp_acc_din", acc_q[k].d, {32'(768 + k), 32'(768 + k)});

    // Reset while a write is pending and stalled
    DDRAM_BUSY = 1'b1;
    for (int i = 0; i < 18; i++) begin
      wr_req = 1'b1; wr_fb = 2'd1; wr_addr = 23'(i * 8); wr_data = 32'(1024 + i);
      tick();
    end
    wr_req = 1'b0;
    chk("prerst_ovf", 64'(overflow), 64'(1));
    chk("prerst_we", 64'(DDRAM_WE), 64'(1));
    rst = 1'b1;
    #1;
    chk("midrst_we", 64'(DDRAM_WE), 64'(0));
    chk("midrst_level", 64'(level), 64'(0));
    chk("midrst_ovf", 64'(overflow), 64'(0));
    chk("midrst_full", 64'(full), 64'(0));
    chk("midrst_addr", 64'(DDRAM_ADDR), 64'(0));
    tick();
    rst = 1'b0;
    DDRAM_BUSY = 1'b0;
    tick();
    single_vec(vt[0]);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
